uart_echo_fifo: RTL

Buffered, parametrised echo engine between a UART core's receive and transmit byte interfaces. Received bytes go into a FIFO and are re-sent one at a time under a start/busy handshake, so back-to-back received bytes are not lost while the transmitter is busy. Optional upper-case folding and CR→CR,LF expansion. Status outputs drive board LEDs.

---
 rtl/uart_echo_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: received bytes queue in a FIFO and are re-sent
// one at a time under a start/busy handshake, with optional case fold and CRLF.
module uart_echo_fifo #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned UPCASE  = 0,
  parameter int unsigned CRLF    = 0,
  parameter int unsigned BUSY_TO = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_error,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       err_seen,
  output logic                       timeout
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam bit IS8 = (DATA_W == 8);
  localparam bit DO_UP = IS8 && (UPCASE != 0);
  localparam bit DO_LF = IS8 && (CRLF != 0);

  typedef enum logic [1:0] {
    IDLE, START, WAIT_BUSY, WAIT_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              lf_q, lf_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              to_q, to_d;

  logic              full, pop, acc;
  logic [DATA_W-1:0] head, fold;

  assign head = mem_q[rd_q];
  assign full = (level_q == LW'(DEPTH));
  // Pending LF blocks the FIFO, so it always follows its CR.
  assign pop  = (state_q == IDLE) && !lf_q &&
                (level_q != '0) && !tx_busy;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign acc  = rx_valid && !rx_error && (!full || pop);

  always_comb begin
    fold = head;
    if (DO_UP && head >= DATA_W'('h61) && head <= DATA_W'('h7A))
      fold = head - DATA_W'('h20);
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    err_d   = err_q | (rx_valid & rx_error);
    if (acc) wr_d = wr_q + AW'(1);
    if (pop) rd_d = rd_q + AW'(1);
    unique case ({acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (rx_valid && !rx_error && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    lf_d       = lf_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    unique case (state_q)
      IDLE: begin
        if (lf_q) begin
          tx_data_d  = DATA_W'('h0A);
          lf_d       = 1'b0;
          tx_start_d = 1'b1;
          state_d    = START;
        end else if (pop) begin
          tx_data_d  = fold;
          lf_d       = DO_LF && (head == DATA_W'('h0D));
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(BUSY_TO)) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      lf_q       <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      lf_q       <= lf_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign err_seen = err_q;
  assign timeout  = to_q;
endmodule
